dmem_access_unit: RTL and testbench

Data-memory access stage directly downstream of the execute-side memory address generator. Consumes the `core::mem_cntrl_bus_t` request (address, `mem_op`, store data, load destination register) and runs a single outstanding request/grant/response transaction on the data-memory port. Stores get byte-lane alignment; load data is extracted, sign- or zero-extended, and delivered to writeback. Stalls the pipeline while the access is in flight and flags misaligned accesses instead of issuing them.

---
 rtl/core.sv | 90 +++++++++
 rtl/load_formatter.sv | 35 +++
 rtl/dmem_access_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_dmem_access_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/core.sv
// -----------------------------------------------------------------------------
// core package (data-memory slice)
// Shared types for the execute -> data-memory path:
//   mem_op_t          memory operation encoding carried on the address bus
//   mem_cntrl_bus_t   request bundle from the address-generation stage
//   dmem_state_t      transaction state of the data-memory access unit
//   mem_width_t       access width decoded from mem_op_t
// Helper functions decode width/sign, store-ness and alignment of an op.
// -----------------------------------------------------------------------------
package core;

    localparam int XLEN        = 32;
    localparam int REG_ADDR_W  = 5;
    localparam int MEM_OP_BITS = 4;

    // The top bit of mem_op distinguishes stores from loads.
    localparam logic STORE_PRFX = 1'b1;

    typedef enum logic [MEM_OP_BITS-1:0] {
        MEM_NOP = 4'b0000,
        MEM_LB  = 4'b0001,
        MEM_LH  = 4'b0010,
        MEM_LW  = 4'b0011,
        MEM_LBU = 4'b0100,
        MEM_LHU = 4'b0101,
        MEM_SB  = 4'b1001,
        MEM_SH  = 4'b1010,
        MEM_SW  = 4'b1011
    } mem_op_t;

    typedef struct packed {
        logic [XLEN-1:0]       addr;
        mem_op_t               mem_op;
        logic [XLEN-1:0]       w_data;
        logic [REG_ADDR_W-1:0] mem_rd;
        logic                  write_en;
        logic [XLEN-1:0]       r_data;
    } mem_cntrl_bus_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RESP = 2'b10,
        DONE = 2'b11
    } dmem_state_t;

    typedef enum logic [1:0] {
        MW_BYTE = 2'b00,
        MW_HALF = 2'b01,
        MW_WORD = 2'b10
    } mem_width_t;

    typedef struct packed {
        mem_width_t width;
        logic       sign;
    } mem_dec_t;

    // Width and signedness of a memory op; stores report signed=0.
    function automatic mem_dec_t decode_mem_op(input mem_op_t op);
        mem_dec_t dec;
        case (op)
            MEM_LB:  begin dec.width = MW_BYTE; dec.sign = 1'b1; end
            MEM_LH:  begin dec.width = MW_HALF; dec.sign = 1'b1; end
            MEM_LW:  begin dec.width = MW_WORD; dec.sign = 1'b0; end
            MEM_LBU: begin dec.width = MW_BYTE; dec.sign = 1'b0; end
            MEM_LHU: begin dec.width = MW_HALF; dec.sign = 1'b0; end
            MEM_SB:  begin dec.width = MW_BYTE; dec.sign = 1'b0; end
            MEM_SH:  begin dec.width = MW_HALF; dec.sign = 1'b0; end
            MEM_SW:  begin dec.width = MW_WORD; dec.sign = 1'b0; end
            default: begin dec.width = MW_WORD; dec.sign = 1'b0; end
        endcase
        return dec;
    endfunction

    function automatic logic is_store_op(input mem_op_t op);
        return (op[MEM_OP_BITS-1] == STORE_PRFX);
    endfunction

    // Halfwords need an even address, words a multiple of four.
    function automatic logic is_misaligned(input logic [1:0] addr_lo, input mem_width_t width);
        logic mis;
        case (width)
            MW_HALF: mis = addr_lo[0];
            MW_WORD: mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_formatter.sv
// -----------------------------------------------------------------------------
// load_formatter
// Combinational load-data alignment: shifts the addressed byte lane down to
// bit 0, then keeps a byte, halfword or word and sign/zero-extends to XLEN.
//   rdata_i    raw 32-bit word returned by memory
//   addr_lo_i  byte offset of the access within the word
//   width_i    access width
//   sign_i     1 = sign-extend, 0 = zero-extend
//   result_o   value to write back
// -----------------------------------------------------------------------------
module load_formatter
    import core::*;
(
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      addr_lo_i,
    input  mem_width_t      width_i,
    input  logic            sign_i,
    output logic [XLEN-1:0] result_o
);

    logic [XLEN-1:0] shifted_s;

    // Lane extraction followed by width selection and extension.
    always_comb begin
        shifted_s = rdata_i >> {addr_lo_i, 3'b000};
        result_o  = shifted_s;
        case (width_i)
            MW_BYTE: result_o = {{(XLEN-8){sign_i & shifted_s[7]}}, shifted_s[7:0]};
            MW_HALF: result_o = {{(XLEN-16){sign_i & shifted_s[15]}}, shifted_s[15:0]};
            MW_WORD: result_o = shifted_s;
            default: result_o = shifted_s;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// -----------------------------------------------------------------------------
// dmem_access_unit
// Data-memory access stage. Takes one request from the address stage, runs a
// single request/grant/response transaction on the data-memory port, aligns
// store lanes, formats load data for writeback and stalls the pipeline while
// the access is in flight. Misaligned accesses are flagged, never issued.
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   mem_bus_i              request (addr, mem_op, w_data, mem_rd used)
//   dmem_req_o/we/addr/be/wdata  memory request port (registered)
//   dmem_gnt_i             request accepted
//   dmem_rvalid_i/rdata_i  read response
//   stall_o                upstream must hold mem_bus_i
//   wb_valid_o/rd/data     load writeback, one-cycle pulse
//   store_done_o           store retired, one-cycle pulse
//   misaligned_o/fault_addr_o  misaligned access report (same cycle)
// -----------------------------------------------------------------------------
module dmem_access_unit
    import core::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  mem_cntrl_bus_t        mem_bus_i,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [XLEN-1:0]       dmem_addr_o,
    output logic [3:0]            dmem_be_o,
    output logic [XLEN-1:0]       dmem_wdata_o,
    input  logic                  dmem_gnt_i,
    input  logic                  dmem_rvalid_i,
    input  logic [XLEN-1:0]       dmem_rdata_i,
    output logic                  stall_o,
    output logic                  wb_valid_o,
    output logic [REG_ADDR_W-1:0] wb_rd_o,
    output logic [XLEN-1:0]       wb_data_o,
    output logic                  store_done_o,
    output logic                  misaligned_o,
    output logic [XLEN-1:0]       fault_addr_o
);

    dmem_state_t           state_q,      state_d;
    logic                  req_q,        req_d;
    logic                  we_q,         we_d;
    logic [XLEN-1:0]       addr_q,       addr_d;
    logic [1:0]            addr_lo_q,    addr_lo_d;
    logic [3:0]            be_q,         be_d;
    logic [XLEN-1:0]       wdata_q,      wdata_d;
    mem_width_t            width_q,      width_d;
    logic                  sign_q,       sign_d;
    logic [REG_ADDR_W-1:0] rd_q,         rd_d;
    logic                  wb_valid_q,   wb_valid_d;
    logic [REG_ADDR_W-1:0] wb_rd_q,      wb_rd_d;
    logic [XLEN-1:0]       wb_data_q,    wb_data_d;
    logic                  store_done_q, store_done_d;

    mem_dec_t        dec_s;
    logic            req_present_s;
    logic            req_store_s;
    logic            req_misal_s;
    logic [XLEN-1:0] fmt_s;
    logic            unused_bus_s;

    // write_en and r_data ride along on the bus but play no part here.
    assign unused_bus_s = ^{mem_bus_i.write_en, mem_bus_i.r_data};

    load_formatter u_load_formatter (
        .rdata_i   (dmem_rdata_i),
        .addr_lo_i (addr_lo_q),
        .width_i   (width_q),
        .sign_i    (sign_q),
        .result_o  (fmt_s)
    );

    // Decode of the incoming request.
    always_comb begin
        dec_s         = decode_mem_op(mem_bus_i.mem_op);
        req_present_s = (mem_bus_i.mem_op != MEM_NOP);
        req_store_s   = is_store_op(mem_bus_i.mem_op);
        req_misal_s   = req_present_s && is_misaligned(mem_bus_i.addr[1:0], dec_s.width);
    end

    // Next-state and next-register logic of the transaction FSM.
    always_comb begin
        state_d      = state_q;
        req_d        = 1'b0;
        we_d         = we_q;
        addr_d       = addr_q;
        addr_lo_d    = addr_lo_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        width_d      = width_q;
        sign_d       = sign_q;
        rd_d         = rd_q;
        wb_valid_d   = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        store_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_present_s && !req_misal_s) begin
                    state_d   = REQ;
                    req_d     = 1'b1;
                    we_d      = req_store_s;
                    addr_d    = {mem_bus_i.addr[XLEN-1:2], 2'b00};
                    addr_lo_d = mem_bus_i.addr[1:0];
                    width_d   = dec_s.width;
                    sign_d    = dec_s.sign;
                    rd_d      = mem_bus_i.mem_rd;
                    if (req_store_s) begin
                        case (dec_s.width)
                            MW_BYTE: begin
                                be_d    = 4'b0001 << mem_bus_i.addr[1:0];
                                wdata_d = {4{mem_bus_i.w_data[7:0]}};
                            end
                            MW_HALF: begin
                                be_d    = mem_bus_i.addr[1] ? 4'b1100 : 4'b0011;
                                wdata_d = {2{mem_bus_i.w_data[15:0]}};
                            end
                            default: begin
                                be_d    = 4'b1111;
                                wdata_d = mem_bus_i.w_data;
                            end
                        endcase
                    end else begin
                        be_d    = 4'b1111;
                        wdata_d = {XLEN{1'b0}};
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (dmem_gnt_i) begin
                    if (we_q) begin
                        state_d      = DONE;
                        store_done_d = 1'b1;
                    end else begin
                        state_d = RESP;
                    end
                end else begin
                    req_d = 1'b1;
                end
            end
            RESP: begin
                if (dmem_rvalid_i) begin
                    state_d    = DONE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = fmt_s;
                end else begin
                    state_d = RESP;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= {XLEN{1'b0}};
            addr_lo_q    <= 2'b00;
            be_q         <= 4'b0000;
            wdata_q      <= {XLEN{1'b0}};
            width_q      <= MW_BYTE;
            sign_q       <= 1'b0;
            rd_q         <= {REG_ADDR_W{1'b0}};
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= {REG_ADDR_W{1'b0}};
            wb_data_q    <= {XLEN{1'b0}};
            store_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            addr_lo_q    <= addr_lo_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            width_q      <= width_d;
            sign_q       <= sign_d;
            rd_q         <= rd_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            store_done_q <= store_done_d;
        end
    end

    // Stall and misalignment react to the bus in the same cycle; the
    // misalignment report is held at zero while reset is asserted.
    always_comb begin
        stall_o      = (state_q == REQ) || (state_q == RESP) ||
                       ((state_q == IDLE) && req_present_s && !req_misal_s);
        misaligned_o = rst_ni && (state_q == IDLE) && req_misal_s;
        if (misaligned_o) begin
            fault_addr_o = mem_bus_i.addr;
        end else begin
            fault_addr_o = {XLEN{1'b0}};
        end
    end

    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_be_o    = be_q;
    assign dmem_wdata_o = wdata_q;
    assign wb_valid_o   = wb_valid_q;
    assign wb_rd_o      = wb_rd_q;
    assign wb_data_o    = wb_data_q;
    assign store_done_o = store_done_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
module tb_dmem_access_unit;
    import core::*;

    logic           clk;
    logic           rst_ni;
    mem_cntrl_bus_t bus;
    logic           dmem_req_o, dmem_we_o;
    logic [31:0]    dmem_addr_o, dmem_wdata_o;
    logic [3:0]     dmem_be_o;
    logic           dmem_gnt_i, dmem_rvalid_i;
    logic [31:0]    dmem_rdata_i;
    logic           stall_o, wb_valid_o, store_done_o, misaligned_o;
    logic [4:0]     wb_rd_o;
    logic [31:0]    wb_data_o, fault_addr_o;

    typedef struct {
        logic        is_store;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    dmem_access_unit dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .mem_bus_i     (bus),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i),
        .stall_o       (stall_o),
        .wb_valid_o    (wb_valid_o),
        .wb_rd_o       (wb_rd_o),
        .wb_data_o     (wb_data_o),
        .store_done_o  (store_done_o),
        .misaligned_o  (misaligned_o),
        .fault_addr_o  (fault_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drive(input mem_op_t op, input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        bus.mem_op = op;
        bus.addr   = a;
        bus.w_data = wd;
        bus.mem_rd = rd;
    endtask

    task automatic push(input logic is_store, input logic [4:0] rd, input logic [31:0] data);
        exp_t e;
        e.is_store = is_store;
        e.rd       = rd;
        e.data     = data;
        sb.push_back(e);
    endtask

    // Store with grant in the first REQ cycle.
    task automatic store_txn(input mem_op_t op, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        cyc(); drive(op, a, wd, 5'd0); push(1'b1, 5'd0, 32'h0);
        smp(); chk("st_stall_n", stall_o, 1); chk("st_req_n", dmem_req_o, 0);
        cyc(); dmem_gnt_i = 1'b1;
        smp(); chk("st_req", dmem_req_o, 1); chk("st_we", dmem_we_o, 1);
               chk("st_be", dmem_be_o, exp_be); chk("st_addr", dmem_addr_o, a & ~32'h3);
               chk("st_wdata", dmem_wdata_o, exp_wdata); chk("st_stall_n1", stall_o, 1);
        cyc(); dmem_gnt_i = 1'b0; drive(MEM_NOP, 32'h0, 32'h0, 5'd0);
        smp(); chk("st_done", store_done_o, 1); chk("st_stall_n2", stall_o, 0);
               chk("st_req_n2", dmem_req_o, 0);
    endtask

    // Load with grant at N+1 and response at N+2.
    task automatic load_txn(input mem_op_t op, input logic [31:0] a, input logic [4:0] rd,
                            input logic [31:0] rdata, input logic [31:0] exp);
        cyc(); drive(op, a, 32'h0, rd); push(1'b0, rd, exp);
        smp(); chk("ld_stall_n", stall_o, 1);
        cyc(); dmem_gnt_i = 1'b1;
        smp(); chk("ld_req", dmem_req_o, 1); chk("ld_we", dmem_we_o, 0);
               chk("ld_be", dmem_be_o, 4'b1111); chk("ld_addr", dmem_addr_o, a & ~32'h3);
        cyc(); dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
        smp(); chk("ld_req_n2", dmem_req_o, 0); chk("ld_stall_n2", stall_o, 1);
               chk("ld_wbv_n2", wb_valid_o, 0);
        cyc(); dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0; drive(MEM_NOP, 32'h0, 32'h0, 5'd0);
        smp(); chk("ld_wbv_n3", wb_valid_o, 1); chk("ld_stall_n3", stall_o, 0);
    endtask

    // Scoreboard: every retirement pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (wb_valid_o || store_done_o) begin
            n_checks++;
            assert (sb.size() !== 0) n_pass++;
            else $error("FAIL sb_unexpected: observed wb_valid=%b store_done=%b expected no retirement",
                        wb_valid_o, store_done_o);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_kind", {30'h0, store_done_o, wb_valid_o}, e.is_store ? 32'h2 : 32'h1);
                if (!e.is_store) begin
                    chk("sb_wb_rd", {27'h0, wb_rd_o}, {27'h0, e.rd});
                    chk("sb_wb_data", wb_data_o, e.data);
                end
            end
        end
    end

    initial begin
        rst_ni        = 1'b0;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'h0;
        bus           = '0;
        bus.mem_op    = MEM_NOP;

        // Reset state.
        cyc(); cyc();
        smp();
        chk("rst_req", dmem_req_o, 0);     chk("rst_we", dmem_we_o, 0);
        chk("rst_addr", dmem_addr_o, 0);   chk("rst_be", dmem_be_o, 0);
        chk("rst_wdata", dmem_wdata_o, 0); chk("rst_stall", stall_o, 0);
        chk("rst_wbv", wb_valid_o, 0);     chk("rst_wbrd", wb_rd_o, 0);
        chk("rst_wbdata", wb_data_o, 0);   chk("rst_sdone", store_done_o, 0);
        chk("rst_misal", misaligned_o, 0); chk("rst_fault", fault_addr_o, 0);
        // Stall follows the IDLE equation even in reset.
        cyc(); drive(MEM_LW, 32'h200, 32'h0, 5'd1);
        smp(); chk("rst_stall_req", stall_o, 1); chk("rst_req_held", dmem_req_o, 0);
        cyc(); drive(MEM_NOP, 32'h0, 32'h0, 5'd0); rst_ni = 1'b1;

        // Stores: word, byte lane, halfword upper lanes.
        store_txn(MEM_SW, 32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
        store_txn(MEM_SB, 32'h102, 32'h123456AB, 4'b0100, 32'hABABABAB);
        store_txn(MEM_SH, 32'h106, 32'h0000BEEF, 4'b1100, 32'hBEEFBEEF);

        // Loads: byte/half sign and zero extension, word with rd=0.
        load_txn(MEM_LB,  32'h103, 5'd5, 32'h80112233, 32'hFFFFFF80);
        load_txn(MEM_LBU, 32'h103, 5'd5, 32'h80112233, 32'h00000080);
        load_txn(MEM_LH,  32'h102, 5'd7, 32'h80011234, 32'hFFFF8001);
        load_txn(MEM_LHU, 32'h102, 5'd7, 32'h80011234, 32'h00008001);
        load_txn(MEM_LW,  32'h104, 5'd0, 32'hCAFEF00D, 32'hCAFEF00D);

        // Misaligned accesses are flagged the same cycle and never issued.
        cyc(); drive(MEM_LW, 32'h102, 32'h0, 5'd4);
        smp(); chk("mis_lw", misaligned_o, 1); chk("mis_lw_fa", fault_addr_o, 32'h102);
               chk("mis_lw_stall", stall_o, 0); chk("mis_lw_req", dmem_req_o, 0);
        cyc();
        smp(); chk("mis_lw_req2", dmem_req_o, 0); chk("mis_lw_hold", misaligned_o, 1);
        cyc(); drive(MEM_LH, 32'h103, 32'h0, 5'd4);
        smp(); chk("mis_lh", misaligned_o, 1); chk("mis_lh_fa", fault_addr_o, 32'h103);
               chk("mis_lh_req", dmem_req_o, 0);
        cyc(); drive(MEM_SW, 32'h101, 32'h1, 5'd0);
        smp(); chk("mis_sw", misaligned_o, 1); chk("mis_sw_stall", stall_o, 0);
               chk("mis_sw_req", dmem_req_o, 0);
        cyc(); drive(MEM_NOP, 32'h0, 32'h0, 5'd0);
        smp(); chk("mis_clr", misaligned_o, 0); chk("mis_clr_fa", fault_addr_o, 0);
               chk("mis_clr_req", dmem_req_o, 0);

        // Slow memory: grant after 3 wait cycles, spurious rvalid in REQ,
        // response after 2 more wait cycles.
        cyc(); drive(MEM_LHU, 32'h10A, 32'h0, 5'd9); push(1'b0, 5'd9, 32'h0000BEEF);
        smp(); chk("slow_stall0", stall_o, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(); dmem_rvalid_i = (i == 1); dmem_rdata_i = 32'hBAD0BAD0;
            smp(); chk("slow_req", dmem_req_o, 1); chk("slow_addr", dmem_addr_o, 32'h108);
                   chk("slow_be", dmem_be_o, 4'b1111); chk("slow_we", dmem_we_o, 0);
                   chk("slow_stall", stall_o, 1); chk("slow_wbv", wb_valid_o, 0);
        end
        cyc(); dmem_rvalid_i = 1'b0; dmem_gnt_i = 1'b1;
        smp(); chk("slow_req_g", dmem_req_o, 1); chk("slow_addr_g", dmem_addr_o, 32'h108);
        for (int i = 0; i < 2; i++) begin
            cyc(); dmem_gnt_i = 1'b0;
            smp(); chk("slow_resp_req", dmem_req_o, 0); chk("slow_resp_stall", stall_o, 1);
                   chk("slow_resp_wbv", wb_valid_o, 0);
        end
        cyc(); dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hBEEF1234;
        smp(); chk("slow_rv_stall", stall_o, 1);
        cyc(); dmem_rvalid_i = 1'b0; drive(MEM_NOP, 32'h0, 32'h0, 5'd0);
        smp(); chk("slow_wbv_done", wb_valid_o, 1); chk("slow_stall_done", stall_o, 0);

        // Reset while waiting for the response.
        cyc(); drive(MEM_LW, 32'h10C, 32'h0, 5'd3);
        smp(); chk("rr_stall", stall_o, 1);
        cyc(); dmem_gnt_i = 1'b1;
        smp(); chk("rr_req", dmem_req_o, 1);
        cyc(); dmem_gnt_i = 1'b0;
        smp(); chk("rr_resp_stall", stall_o, 1); chk("rr_resp_req", dmem_req_o, 0);
        #1; rst_ni = 1'b0; drive(MEM_NOP, 32'h0, 32'h0, 5'd0);
        #1;
        chk("rr_req0", dmem_req_o, 0);   chk("rr_we0", dmem_we_o, 0);
        chk("rr_addr0", dmem_addr_o, 0); chk("rr_be0", dmem_be_o, 0);
        chk("rr_stall0", stall_o, 0);    chk("rr_wbv0", wb_valid_o, 0);
        chk("rr_wbrd0", wb_rd_o, 0);     chk("rr_misal0", misaligned_o, 0);
        cyc(); rst_ni = 1'b1;
        cyc(); dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h55555555;
        smp(); chk("rr_late_wbv", wb_valid_o, 0); chk("rr_late_stall", stall_o, 0);
        cyc(); dmem_rvalid_i = 1'b0;
        smp(); chk("rr_late_wbv2", wb_valid_o, 0); chk("rr_late_req", dmem_req_o, 0);
        cyc();
        smp(); chk("rr_late_wbv3", wb_valid_o, 0); chk("rr_late_wbdata", wb_data_o, 0);

        // Recovery after reset.
        store_txn(MEM_SH, 32'h104, 32'h00001357, 4'b0011, 32'h13571357);

        cyc();
        smp(); chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
